// File: rtl/instr_fetch_queue_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_queue_if
//   Handshake and bus bundle for the dual-issue instruction fetch queue.
//
//   Program load : prog_we, prog_addr, prog_wdata
//   Redirect     : redirect_valid, redirect_pc
//   Consume      : take (0..2 instructions per cycle, 3 is treated as 2)
//   Decode slots : slot0_* (oldest) and slot1_* (second oldest)
//
//   master : the environment side (drives load/redirect/take, observes slots)
//   slave  : the fetch unit side
// -----------------------------------------------------------------------------
interface instr_fetch_queue_if #(
    parameter int ADDR_W = 8
);
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [31:0]       prog_wdata;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic [1:0]        take;
    logic              slot0_valid;
    logic [31:0]       slot0_instr;
    logic [ADDR_W-1:0] slot0_pc;
    logic              slot1_valid;
    logic [31:0]       slot1_instr;
    logic [ADDR_W-1:0] slot1_pc;

    modport master (
        output prog_we, prog_addr, prog_wdata,
        output redirect_valid, redirect_pc, take,
        input  slot0_valid, slot0_instr, slot0_pc,
        input  slot1_valid, slot1_instr, slot1_pc
    );

    modport slave (
        input  prog_we, prog_addr, prog_wdata,
        input  redirect_valid, redirect_pc, take,
        output slot0_valid, slot0_instr, slot0_pc,
        output slot1_valid, slot1_instr, slot1_pc
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// instr_fetch_queue
//   Dual-issue instruction fetch unit: a little-endian instruction memory and a
//   circular queue of fetched instructions. Each cycle up to two consecutive
//   words are fetched from fetch_pc; the two oldest queued instructions are
//   presented to decode together with their PCs.
//
// Ports:
//   clk               clock, rising edge
//   reset             asynchronous, active-high reset
//   bus (slave)       program load, redirect, take and the two decode slots
//   perf_empty_cycles (only with FETCH_PERF_EN) saturating count of edges
//                     where the queue was empty and no redirect was taken
//
// Optional feature macro: FETCH_PERF_EN
// -----------------------------------------------------------------------------
module instr_fetch_queue #(
    parameter int                ADDR_W      = 8,
    parameter int                MEM_BYTES   = 128,
    parameter int                QUEUE_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
    input  logic                clk,
    input  logic                reset,
`ifdef FETCH_PERF_EN
    output logic [15:0]         perf_empty_cycles,
`endif
    instr_fetch_queue_if.slave  bus
);
    localparam int MEM_WORDS = MEM_BYTES / 4;
    localparam int WIDX_W    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int PTR_W     = $clog2(QUEUE_DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int EXT_W     = ADDR_W + 4;

    // All accesses are word aligned, so the byte array is held one word per
    // entry with byte a+0 in bits [7:0] (little endian).
    logic [31:0]       mem     [MEM_WORDS];
    logic [31:0]       q_instr [QUEUE_DEPTH];
    logic [ADDR_W-1:0] q_pc    [QUEUE_DEPTH];

    logic [ADDR_W-1:0] fetch_pc;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;

    logic [ADDR_W-1:0] pc1;
    logic [31:0]       word0;
    logic [31:0]       word1;
    logic              fit0;
    logic              fit1;
    logic              room;
    logic [1:0]        n_push;
    logic [1:0]        take_eff;
    logic [1:0]        n_pop;

    // Extended-width compares so fetch_pc+7 cannot wrap past the end of memory.
    assign pc1   = fetch_pc + ADDR_W'(4);
    assign fit0  = (EXT_W'(fetch_pc) + EXT_W'(3)) < EXT_W'(MEM_BYTES);
    assign fit1  = (EXT_W'(fetch_pc) + EXT_W'(7)) < EXT_W'(MEM_BYTES);
    assign word0 = fit0 ? mem[WIDX_W'(fetch_pc >> 2)] : '0;
    assign word1 = fit1 ? mem[WIDX_W'(pc1 >> 2)]      : '0;
    // Pushes are pair-granular: only fetch when two entries are free.
    assign room  = count <= CNT_W'(QUEUE_DEPTH - 2);

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        n_push = 2'd0;
        if (!bus.redirect_valid && room) begin
            if (fit1)      n_push = 2'd2;
            else if (fit0) n_push = 2'd1;
        end
        take_eff = (bus.take == 2'd3) ? 2'd2 : bus.take;
        if (CNT_W'(take_eff) > count) n_pop = count[1:0];
        else                          n_pop = take_eff;
    end

    // NOTE: state registers use non-blocking assignments so every block samples
    // the pre-edge values, whatever the evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (bus.redirect_valid) begin
            fetch_pc <= bus.redirect_pc & ~ADDR_W'(3);
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            fetch_pc <= fetch_pc + ADDR_W'({n_push, 2'b00});
            wr_ptr   <= wr_ptr + PTR_W'(n_push);
            rd_ptr   <= rd_ptr + PTR_W'(n_pop);
            count    <= count + CNT_W'(n_push) - CNT_W'(n_pop);
        end
    end

    // NOTE: queue and instruction storage carry no reset; validity comes solely
    // from count, so reset only clears the pointers.
    always_ff @(posedge clk) begin
        if (n_push != 2'd0) begin
            q_instr[wr_ptr] <= word0;
            q_pc[wr_ptr]    <= fetch_pc;
        end
        if (n_push == 2'd2) begin
            q_instr[wr_ptr + PTR_W'(1)] <= word1;
            q_pc[wr_ptr + PTR_W'(1)]    <= pc1;
        end
    end

    // Fetch reads above see the old word on a same-edge write.
    always_ff @(posedge clk) begin
        if (bus.prog_we && (EXT_W'(bus.prog_addr) < EXT_W'(MEM_BYTES)))
            mem[WIDX_W'(bus.prog_addr >> 2)] <= bus.prog_wdata;
    end

    logic [PTR_W-1:0] rd_ptr1;
    assign rd_ptr1 = rd_ptr + PTR_W'(1);

    always_comb begin
        bus.slot0_valid = 1'b0;
        bus.slot0_instr = '0;
        bus.slot0_pc    = '0;
        bus.slot1_valid = 1'b0;
        bus.slot1_instr = '0;
        bus.slot1_pc    = '0;
        if (count != '0) begin
            bus.slot0_valid = 1'b1;
            bus.slot0_instr = q_instr[rd_ptr];
            bus.slot0_pc    = q_pc[rd_ptr];
        end
        if (count >= CNT_W'(2)) begin
            bus.slot1_valid = 1'b1;
            bus.slot1_instr = q_instr[rd_ptr1];
            bus.slot1_pc    = q_pc[rd_ptr1];
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            perf_empty_cycles <= '0;
        else if (count == '0 && !bus.redirect_valid && perf_empty_cycles != 16'hFFFF)
            perf_empty_cycles <= perf_empty_cycles + 16'd1;
    end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_queue
//   Self-checking bench for instr_fetch_queue. A behavioural model (byte
//   memory, a queue of {pc, instr} entries, a fetch PC) is advanced once per
//   clock edge from the fetch/pop/redirect rules; the decode slots are compared
//   against the model one time unit after each rising edge.
//   Honours FETCH_PERF_EN for the optional empty-cycle counter.
// -----------------------------------------------------------------------------
module tb_instr_fetch_queue;
    localparam int ADDR_W      = 8;
    localparam int MEM_BYTES   = 128;
    localparam int QUEUE_DEPTH = 4;

    typedef logic [81:0] slots_t;
    typedef struct {
        logic [7:0]  pc;
        logic [31:0] instr;
    } ent_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    instr_fetch_queue_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef FETCH_PERF_EN
    logic [15:0] perf_empty_cycles;
    int          perf_m = 0;
`endif

    instr_fetch_queue #(
        .ADDR_W      (ADDR_W),
        .MEM_BYTES   (MEM_BYTES),
        .QUEUE_DEPTH (QUEUE_DEPTH),
        .RESET_PC    (8'h00)
    ) dut (
        .clk               (clk),
        .reset             (reset),
`ifdef FETCH_PERF_EN
        .perf_empty_cycles (perf_empty_cycles),
`endif
        .bus               (bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0] mem_m [MEM_BYTES];
    ent_t       q_m[$];
    int         fpc_m = 0;

    function automatic logic [31:0] word_m(int a);
        return {mem_m[a+3], mem_m[a+2], mem_m[a+1], mem_m[a]};
    endfunction

    function automatic slots_t slots_obs();
        return {bus.slot0_valid, bus.slot0_pc, bus.slot0_instr,
                bus.slot1_valid, bus.slot1_pc, bus.slot1_instr};
    endfunction

    function automatic slots_t slots_exp();
        slots_t v = '0;
        if (q_m.size() >= 1) v[81:41] = {1'b1, q_m[0].pc, q_m[0].instr};
        if (q_m.size() >= 2) v[40:0]  = {1'b1, q_m[1].pc, q_m[1].instr};
        return v;
    endfunction

    // Advance model by one edge using current inputs, then clock the DUT.
    task automatic step();
        int   fit, n, t, pop, a;
        ent_t e;
        if (bus.redirect_valid) begin
            q_m.delete();
            fpc_m = int'(bus.redirect_pc) & ~3;
        end else begin
`ifdef FETCH_PERF_EN
            if (q_m.size() == 0 && perf_m < 65535) perf_m++;
`endif
            fit = 0;
            for (int k = 0; k < 2; k++)
                if (fpc_m + 4*k + 3 < MEM_BYTES) fit++;
            n   = (QUEUE_DEPTH - q_m.size() >= 2) ? fit : 0;
            t   = (bus.take == 2'd3) ? 2 : int'(bus.take);
            pop = (t < q_m.size()) ? t : q_m.size();
            repeat (pop) void'(q_m.pop_front());
            for (int k = 0; k < n; k++) begin
                e.pc    = 8'(fpc_m + 4*k);
                e.instr = word_m(fpc_m + 4*k);
                q_m.push_back(e);
            end
            fpc_m += 4*n;
        end
        if (bus.prog_we && int'(bus.prog_addr) < MEM_BYTES) begin
            a = int'(bus.prog_addr) & ~3;
            for (int b = 0; b < 4; b++) mem_m[a+b] = bus.prog_wdata[8*b +: 8];
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] init_words [4];
        init_words = '{32'h00a00093, 32'h01400113, 32'h01e00193, 32'h02800213};
        bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_wdata = '0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.take = 2'd0;
        reset = 1'b1;
        #12;
        total++;
        if (slots_obs() !== '0) begin
            bad++; $display("FAIL reset_outputs: got %h want 0", slots_obs());
        end
        @(negedge clk);
        reset = 1'b0;
        // Load the program while redirect holds the queue empty.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 8'h00;
        for (int w = 0; w < MEM_BYTES/4; w++) begin
            bus.prog_we    = 1'b1;
            bus.prog_addr  = 8'(4*w);
            bus.prog_wdata = (w < 4) ? init_words[w] : $urandom;
            step();
        end
        bus.prog_we = 1'b0;
        total++;
        if (slots_obs() !== '0) begin
            bad++; $display("FAIL load_idle: got %h want 0", slots_obs());
        end
        bus.redirect_valid = 1'b0;
        bus.take = 2'd0;
    endtask

    task automatic test_first_fetch();
        slots_t want;
        want = {1'b1, 8'h00, 32'h00a00093, 1'b1, 8'h04, 32'h01400113};
        step();
        total++;
        if (slots_obs() !== want) begin
            bad++; $display("FAIL first_fetch: got %h want %h", slots_obs(), want);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (slots_obs() !== want) begin
                bad++; $display("FAIL hold_take0_%0d: got %h want %h", i, slots_obs(), want);
            end
        end
    endtask

    task automatic test_steady_drain();
        logic [8:0] want_pc;
        bus.take = 2'd2;
        for (int i = 1; i <= 6; i++) begin
            step();
            total++;
            if ({bus.slot0_valid, bus.slot0_pc} !== {1'b1, 8'(8*i)}) begin
                bad++; $display("FAIL drain2_pc_%0d: got %b/%h want 1/%h",
                                i, bus.slot0_valid, bus.slot0_pc, 8'(8*i));
            end
            total++;
            if (slots_obs() !== slots_exp()) begin
                bad++; $display("FAIL drain2_model_%0d: got %h want %h", i, slots_obs(), slots_exp());
            end
        end
        want_pc  = {1'b1, 8'h30};
        bus.take = 2'd1;
        for (int i = 1; i <= 6; i++) begin
            step();
            want_pc[7:0] = want_pc[7:0] + 8'd4;
            total++;
            if ({bus.slot0_valid, bus.slot0_pc} !== want_pc) begin
                bad++; $display("FAIL drain1_pc_%0d: got %b/%h want %h",
                                i, bus.slot0_valid, bus.slot0_pc, want_pc);
            end
        end
        bus.take = 2'd0;
    endtask

    task automatic test_redirect();
        slots_t want;
        step(); step(); step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 8'h12;
        bus.take           = 2'd2;
        step();
        total++;
        if (slots_obs() !== '0) begin
            bad++; $display("FAIL redirect_flush: got %h want 0", slots_obs());
        end
        bus.redirect_valid = 1'b0;
        bus.take           = 2'd0;
        step();
        want = {1'b1, 8'h10, word_m(16), 1'b1, 8'h14, word_m(20)};
        total++;
        if (slots_obs() !== want) begin
            bad++; $display("FAIL redirect_refetch: got %h want %h", slots_obs(), want);
        end
    endtask

    task automatic test_end_of_mem();
        slots_t want;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 8'h7C;
        step();
        bus.redirect_valid = 1'b0;
        want = {1'b1, 8'h7C, word_m(124), 41'b0};
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (slots_obs() !== want) begin
                bad++; $display("FAIL end_of_mem_%0d: got %h want %h", i, slots_obs(), want);
            end
        end
        bus.take = 2'd1;
        step();
        bus.take = 2'd0;
        step();
        total++;
        if (slots_obs() !== '0) begin
            bad++; $display("FAIL end_stall: got %h want 0", slots_obs());
        end
    endtask

    task automatic test_over_take();
        slots_t want;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 8'h78;
        step();
        bus.redirect_valid = 1'b0;
        step();
        bus.take = 2'd1;
        step();
        want = {1'b1, 8'h7C, word_m(124), 41'b0};
        total++;
        if (slots_obs() !== want) begin
            bad++; $display("FAIL count1: got %h want %h", slots_obs(), want);
        end
        bus.take = 2'd2;
        step();
        total++;
        if (slots_obs() !== '0) begin
            bad++; $display("FAIL overtake2: got %h want 0", slots_obs());
        end
        bus.take           = 2'd0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 8'h20;
        step();
        bus.redirect_valid = 1'b0;
        step(); step();
        bus.take = 2'd3;
        step();
        want = {1'b1, 8'h28, word_m(40), 1'b1, 8'h2C, word_m(44)};
        total++;
        if (slots_obs() !== want) begin
            bad++; $display("FAIL take3: got %h want %h", slots_obs(), want);
        end
        bus.take = 2'd0;
    endtask

    task automatic test_async_reset();
        slots_t want;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 8'h00;
        step();
        bus.redirect_valid = 1'b0;
        bus.take = 2'd0;
        step();
        bus.take = 2'd1;
        step();
        want = {1'b1, 8'h04, 32'h01400113, 1'b1, 8'h08, 32'h01e00193};
        total++;
        if (slots_obs() !== want) begin
            bad++; $display("FAIL pre_reset_count3: got %h want %h", slots_obs(), want);
        end
        #2 reset = 1'b1;
        #1;
        q_m.delete();
        fpc_m = 0;
        total++;
        if (slots_obs() !== '0) begin
            bad++; $display("FAIL async_reset_outputs: got %h want 0", slots_obs());
        end
`ifdef FETCH_PERF_EN
        perf_m = 0;
        total++;
        if (perf_empty_cycles !== 16'd0) begin
            bad++; $display("FAIL perf_reset: got %0d want 0", perf_empty_cycles);
        end
`endif
        #2 reset = 1'b0;
        bus.take = 2'd0;
        step();
        want = {1'b1, 8'h00, 32'h00a00093, 1'b1, 8'h04, 32'h01400113};
        total++;
        if (slots_obs() !== want) begin
            bad++; $display("FAIL refetch_after_reset: got %h want %h", slots_obs(), want);
        end
`ifdef FETCH_PERF_EN
        step();
        total++;
        if (perf_empty_cycles !== 16'd1) begin
            bad++; $display("FAIL perf_one_empty: got %0d want 1", perf_empty_cycles);
        end
`endif
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 400; i++) begin
            bus.redirect_valid = ($urandom_range(0, 15) == 0);
            bus.redirect_pc    = 8'($urandom_range(0, 135));
            bus.take           = 2'($urandom_range(0, 3));
            bus.prog_we        = ($urandom_range(0, 7) == 0);
            bus.prog_addr      = 8'($urandom_range(0, MEM_BYTES - 1));
            bus.prog_wdata     = $urandom;
            step();
            total++;
            if (slots_obs() !== slots_exp()) begin
                bad++; $display("FAIL random_%0d: got %h want %h", i, slots_obs(), slots_exp());
            end
`ifdef FETCH_PERF_EN
            total++;
            if (perf_empty_cycles !== 16'(perf_m)) begin
                bad++; $display("FAIL perf_random_%0d: got %0d want %0d", i, perf_empty_cycles, perf_m);
            end
`endif
        end
        bus.prog_we        = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.take           = 2'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_fetch();
        test_steady_drain();
        test_redirect();
        test_end_of_mem();
        test_over_take();
        test_async_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Parametrised dual-issue instruction fetch unit: byte-addressed little-endian instruction memory plus a circular fetch queue.
- Each cycle it fetches up to two consecutive 32-bit words from fetch_pc into the queue.
- It presents the two oldest queued instructions, with their PCs, to decode.
- The consumer takes 0, 1 or 2 per cycle. A redirect port (branch/jump) flushes the queue. A word-write port loads the program.

Parameters:
- ADDR_W, 8, byte-address width of PCs and memory.
- MEM_BYTES, 128, memory size in bytes; multiple of 4, at most 2^ADDR_W.
- QUEUE_DEPTH, 4, queue entries (one instruction each); power of 2, at least 2.
- RESET_PC, 0, fetch_pc value after reset; word-aligned.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- prog_we  in  1  program-load word write enable.
- prog_addr  in  ADDR_W  write byte address; bits [1:0] ignored.
- prog_wdata  in  32  write word; byte 0 = bits [7:0].
- redirect_valid  in  1  flush queue and restart fetch.
- redirect_pc  in  ADDR_W  new fetch PC; bits [1:0] forced to 0.
- take  in  2  number of instructions consumed this cycle (0..2).
- slot0_valid  out  1  oldest queue entry is valid.
- slot0_instr  out  32  oldest instruction; 0 when not valid.
- slot0_pc  out  ADDR_W  PC of slot0; 0 when not valid.
- slot1_valid  out  1  second-oldest entry is valid.
- slot1_instr  out  32  second-oldest instruction; 0 when not valid.
- slot1_pc  out  ADDR_W  PC of slot1; 0 when not valid.

Behaviour:
- Reset (async): fetch_pc=RESET_PC, rd/wr pointers=0, count=0. All outputs 0 immediately. Memory contents are not reset.
- Memory: MEM_BYTES x 8 array. Fetch reads are combinational and assemble word = {m[a+3],m[a+2],m[a+1],m[a]}. A prog_we write updates bytes [a..a+3] at the edge and is visible to fetch reads from the next cycle.
- Fetch, per edge, when redirect_valid=0:
  - fit = number of words with fetch_pc+4k+3 < MEM_BYTES, k=0..1, capped at 2.
  - free = QUEUE_DEPTH - count, using count before this cycle's pop.
  - n = min(fit, 2) if free >= 2; otherwise 0. Pushes are pair-granular except at end of memory, where n may be 1.
  - Push n words with their PCs; fetch_pc += 4n.
  - When fit=0, fetch stalls at fetch_pc until a redirect arrives.
- Latency: a word pushed at edge E appears on slot0 or slot1 after E, i.e. one cycle after its fetch_pc is current.
- Outputs: slot0 is the queue head when count >= 1; slot1 is head+1 when count >= 2. Both are combinational from registered queue state.
- Pop, per edge:
  - effective take = min(take, count), with take=3 treated as 2.
  - rd pointer += effective take.
  - Simultaneous push and pop are allowed: count_next = count + n - pop.
- Redirect: redirect_valid=1 at edge E does the following at E:
  - count=0 and rd=wr=0.
  - fetch_pc = redirect_pc & ~3.
  - take is ignored and nothing is pushed.
  - Fetch from the new PC starts at edge E+1. Slots are invalid for the cycle after E.
- Pointers wrap modulo QUEUE_DEPTH. Count ranges 0..QUEUE_DEPTH and never overflows, given the free>=2 rule.
- prog_we concurrent with a fetch of the same address: the fetch pushes the old data.

Optional Feature:
- FETCH_PERF_EN defined:
  - Adds output port perf_empty_cycles [15:0], reset to 0.
  - Increments each edge where count==0 and redirect_valid==0.
  - Saturates at 0xFFFF.
- FETCH_PERF_EN undefined: the port and counter do not exist. All other behaviour is identical.

Test Plan:
- Reset/first fetch: memory words at 0x0..0xC = 00a00093, 01400113, 01e00193, 02800213; take=0.
  - After edge 1: slot0=00a00093/pc 0x00, slot1=01400113/pc 0x04.
  - After edge 2: count=4. No further pushes while take=0.
- Steady drain: take=2 every cycle from a full queue → pc0 sequence 0x00, 0x08, 0x10, ... with no bubble after the first cycle.
  - take=1 → pc0 advances by 4 per cycle.
- Redirect: redirect_valid=1 with redirect_pc=0x12 while queue is full → next cycle both valids=0. One cycle later slot0 = word at 0x10, pc 0x10, and slot1 = word at 0x14.
- End of memory: MEM_BYTES=128, redirect to 0x7C → single push; slot0 pc=0x7C valid, slot1_valid=0. fetch_pc=0x80 and no further pushes.
- Over-take: count=1 and take=2 → only slot0 popped; count=0 and slot1 unaffected. take=3 with count=4 → 2 popped.
- Async reset mid-run: assert reset between edges with count=3 → all outputs 0 immediately. After deassert, refetch from RESET_PC=0 gives slot0=00a00093.
  - With FETCH_PERF_EN: perf_empty_cycles increments by exactly 1 per empty non-redirect edge.
